// File: rtl/vid_sync_hv_gen_if.sv
// Raster timing bundle from the sync generator to the OSD/layer engines.
// The master modport drives the bundle. The slave modport receives it.
interface vid_sync_hv_gen_if;
  logic [3:0]  pc_ena;
  logic        hde;
  logic        vde;
  logic        hs;
  logic        vs;
  logic [47:0] HV_triggers;
  logic        frame_start;
  logic [11:0] raster_x;
  logic [11:0] raster_y;

  modport master (
    output pc_ena, hde, vde, hs, vs, HV_triggers, frame_start, raster_x, raster_y
  );

  modport slave (
    input pc_ena, hde, vde, hs, vs, HV_triggers, frame_start, raster_x, raster_y
  );
endinterface

// File: rtl/vid_sync_hv_gen.sv
// Raster timing source: sub-pixel phase, h/v counters, and syncs/enables.
// It also drives the 48-bit per-pixel trigger bus that feeds the layer engines.
module vid_sync_hv_gen #(
  parameter int PC_DIV   = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  vid_sync_hv_gen_if.master vid
);

  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START  = H_ACTIVE + H_FRONT;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FRONT;
  localparam int VS_END    = VS_START + V_SYNC;
  localparam int TRIG_BASE = H_TOTAL - 48;

  logic [3:0]  pc_r;
  logic [11:0] h_r;
  logic [11:0] v_r;
  logic        hde_r, vde_r, hs_r, vs_r, frame_start_r;
  logic [47:0] trig_r;
  logic [11:0] raster_x_r, raster_y_r;

  logic        advance_s;
  logic [3:0]  pc_nxt_s;
  logic [11:0] h_nxt_s, v_nxt_s;
  logic [12:0] h13_s, v13_s;
  logic        hde_nxt_s, vde_nxt_s, hs_nxt_s, vs_nxt_s, fs_nxt_s, line_ok_s;
  logic [5:0]  trig_idx_s;
  logic [47:0] trig_nxt_s;

  // Next position and decode of that new position, loaded only on an advance.
  always_comb begin
    advance_s  = (pc_r == 4'(PC_DIV - 1));
    pc_nxt_s   = advance_s ? 4'd0 : (pc_r + 4'd1);
    h_nxt_s    = (h_r == 12'(H_TOTAL - 1)) ? 12'd0 : (h_r + 12'd1);
    v_nxt_s    = v_r;
    if (h_r == 12'(H_TOTAL - 1)) begin
      v_nxt_s = (v_r == 12'(V_TOTAL - 1)) ? 12'd0 : (v_r + 12'd1);
    end else begin
      v_nxt_s = v_r;
    end
    // 13-bit compares keep bounds equal to 4096 from wrapping to zero.
    h13_s      = {1'b0, h_nxt_s};
    v13_s      = {1'b0, v_nxt_s};
    hde_nxt_s  = (h13_s < 13'(H_ACTIVE));
    vde_nxt_s  = (v13_s < 13'(V_ACTIVE));
    hs_nxt_s   = ((h13_s >= 13'(HS_START)) && (h13_s < 13'(HS_END))) ? HS_POL : ~HS_POL;
    vs_nxt_s   = ((v13_s >= 13'(VS_START)) && (v13_s < 13'(VS_END))) ? VS_POL : ~VS_POL;
    fs_nxt_s   = (h_nxt_s == 12'd0) && (v_nxt_s == 12'd0);
    line_ok_s  = (v_nxt_s == 12'(V_TOTAL - 1)) || (v13_s < 13'(V_ACTIVE - 1));
    trig_idx_s = 6'(h_nxt_s - 12'(TRIG_BASE));
    if ((h_nxt_s >= 12'(TRIG_BASE)) && line_ok_s) begin
      trig_nxt_s = 48'd1 << trig_idx_s;
    end else begin
      trig_nxt_s = 48'd0;
    end
  end

  // Phase counter, position counters, and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= 4'd0;
      h_r           <= 12'(H_TOTAL - 1);
      v_r           <= 12'(V_TOTAL - 1);
      hde_r         <= 1'b0;
      vde_r         <= 1'b0;
      hs_r          <= ~HS_POL;
      vs_r          <= ~VS_POL;
      frame_start_r <= 1'b0;
      trig_r        <= 48'd0;
      raster_x_r    <= 12'd0;
      raster_y_r    <= 12'd0;
    end else begin
      pc_r <= pc_nxt_s;
      if (advance_s) begin
        h_r           <= h_nxt_s;
        v_r           <= v_nxt_s;
        hde_r         <= hde_nxt_s;
        vde_r         <= vde_nxt_s;
        hs_r          <= hs_nxt_s;
        vs_r          <= vs_nxt_s;
        frame_start_r <= fs_nxt_s;
        trig_r        <= trig_nxt_s;
        raster_x_r    <= h_nxt_s;
        raster_y_r    <= v_nxt_s;
      end
    end
  end

  assign vid.pc_ena      = pc_r;
  assign vid.hde         = hde_r;
  assign vid.vde         = vde_r;
  assign vid.hs          = hs_r;
  assign vid.vs          = vs_r;
  assign vid.frame_start = frame_start_r;
  assign vid.HV_triggers = trig_r;
  assign vid.raster_x    = raster_x_r;
  assign vid.raster_y    = raster_y_r;

endmodule

// File: tb/tb_vid_sync_hv_gen.sv
// Bench for vid_sync_hv_gen. Three geometries run side by side against a closed-form raster model.
// A reset-release vector table, hand corner sequences, and random reset bursts cover the corner cases.
module tb_vid_sync_hv_gen;

  typedef struct packed {
    logic [3:0]  pc;
    logic        hde, vde, hs, vs, fs;
    logic [47:0] trig;
    logic [11:0] rx, ry;
  } outs_t;

  typedef struct {
    int pc;
    bit hde, vde, fs;
    int rx, ry;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests, fails, n;
  bit   chk_en;

  always #5 clk = ~clk;

  vid_sync_hv_gen_if ifa ();
  vid_sync_hv_gen_if ifb ();
  vid_sync_hv_gen_if ifd ();

  vid_sync_hv_gen #(.PC_DIV(4), .H_ACTIVE(64), .H_FRONT(8), .H_SYNC(12), .H_BACK(40),
                    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                    .HS_POL(1'b0), .VS_POL(1'b0))
    dut_a (.clk(clk), .reset(reset), .vid(ifa));

  vid_sync_hv_gen #(.PC_DIV(1), .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
                    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                    .HS_POL(1'b1), .VS_POL(1'b1))
    dut_b (.clk(clk), .reset(reset), .vid(ifb));

  vid_sync_hv_gen dut_d (.clk(clk), .reset(reset), .vid(ifd));

  // Position is a pure function of edges since reset: n edges -> pixel n/PC_DIV-1.
  function automatic outs_t model(int cnt, int pd, int ha, int hf, int hsy, int hb,
                                  int va, int vf, int vsy, int vb, bit hp, bit vp);
    outs_t o;
    int ht, vt, p, h, v;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    o = '0;
    o.pc = 4'(cnt % pd);
    o.hs = ~hp;
    o.vs = ~vp;
    if (cnt >= pd) begin
      p = cnt / pd - 1;
      h = p % ht;
      v = (p / ht) % vt;
      o.hde = (h < ha);
      o.vde = (v < va);
      o.hs  = (h >= ha + hf && h < ha + hf + hsy) ? hp : ~hp;
      o.vs  = (v >= va + vf && v < va + vf + vsy) ? vp : ~vp;
      o.fs  = (h == 0 && v == 0);
      if (h >= ht - 48 && (v == vt - 1 || v < va - 1)) o.trig = 48'd1 << (h - (ht - 48));
      o.rx = 12'(h);
      o.ry = 12'(v);
    end
    return o;
  endfunction

  function automatic outs_t get_a();
    return {ifa.pc_ena, ifa.hde, ifa.vde, ifa.hs, ifa.vs, ifa.frame_start,
            ifa.HV_triggers, ifa.raster_x, ifa.raster_y};
  endfunction

  function automatic outs_t get_b();
    return {ifb.pc_ena, ifb.hde, ifb.vde, ifb.hs, ifb.vs, ifb.frame_start,
            ifb.HV_triggers, ifb.raster_x, ifb.raster_y};
  endfunction

  function automatic outs_t get_d();
    return {ifd.pc_ena, ifd.hde, ifd.vde, ifd.hs, ifd.vs, ifd.frame_start,
            ifd.HV_triggers, ifd.raster_x, ifd.raster_y};
  endfunction

  task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge count %0d)", name, act, exp, n);
    end
  endtask

  // One clock; every instance is compared against the model at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) n = 0;
    else n = n + 1;
    @(negedge clk);
    if (chk_en) begin
      check("model_a", get_a(), model(n, 4, 64, 8, 12, 40, 6, 2, 2, 3, 1'b0, 1'b0));
      check("model_b", get_b(), model(n, 1, 640, 16, 96, 48, 6, 2, 2, 3, 1'b1, 1'b1));
      check("model_d", get_d(), model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    end
  endtask

  function automatic bit sig(int sel);
    case (sel)
      0:       return ifa.hde;
      1:       return ~ifa.hs;
      2:       return ifb.hs;
      default: return ifa.frame_start;
    endcase
  endfunction

  // Pulse width, or rising-to-rising period, in clks; -1 if the bound expires.
  task automatic measure(input int sel, input bit period, output int len);
    int guard;
    guard = 0;
    len = 0;
    while (sig(sel) && guard < 20000) begin tick(); guard++; end
    while (!sig(sel) && guard < 20000) begin tick(); guard++; end
    while (sig(sel) && guard < 20000) begin len++; tick(); guard++; end
    if (period) begin
      while (!sig(sel) && guard < 20000) begin len++; tick(); guard++; end
    end
    if (guard >= 20000) len = -1;
  endtask

  task automatic wait_at(input int x, input int y, output bit ok);
    int guard;
    guard = 0;
    while (!(ifa.raster_x == 12'(x) && ifa.raster_y == 12'(y) && ifa.pc_ena == 4'd0)
           && guard < 20000) begin
      tick();
      guard++;
    end
    ok = (guard < 20000);
  endtask

  initial begin
    vec_t  vecs[9];
    outs_t rst_exp;
    int    len, cnt;
    bit    ok, stray;

    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[2] = '{2, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[3] = '{3, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4] = '{0, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{1, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{2, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[7] = '{3, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[8] = '{0, 1'b1, 1'b1, 1'b0, 1, 0};

    tests = 0;
    fails = 0;
    n = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();

    // Release sequence: entry 0 is the last reset edge, entries 1..8 follow.
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      check($sformatf("release_vec%0d", i),
            {ifa.pc_ena, ifa.hde, ifa.vde, ifa.frame_start, ifa.raster_x, ifa.raster_y},
            {4'(vecs[i].pc), vecs[i].hde, vecs[i].vde, vecs[i].fs,
             12'(vecs[i].rx), 12'(vecs[i].ry)});
      reset = 1'b0;
    end

    measure(0, 1'b0, len);
    check("hde_width_a", 81'(len), 81'(64 * 4));
    measure(1, 1'b0, len);
    check("hs_low_width_a", 81'(len), 81'(12 * 4));
    measure(2, 1'b0, len);
    check("hs_high_width_b", 81'(len), 81'(96));
    measure(3, 1'b1, len);
    check("frame_period_a", 81'(len), 81'(124 * 13 * 4));

    wait_at(84, 0, ok);
    check("trig8_v0", {ok, ifa.HV_triggers}, {1'b1, 48'h100});
    wait_at(84, 5, ok);
    check("trig_last_active", {ok, ifa.HV_triggers}, {1'b1, 48'h0});
    wait_at(94, 12, ok);
    check("trig18_vlast", {ok, ifa.HV_triggers}, {1'b1, 48'h40000});

    // Mid-frame reset: hold values throughout, then restart PC_DIV clks after release.
    wait_at(30, 3, ok);
    check("reach_mid", 81'(ok), 81'(1));
    tick();
    rst_exp = '0;
    rst_exp.hs = 1'b1;
    rst_exp.vs = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold", get_a(), rst_exp);
    end
    reset = 1'b0;
    cnt = 0;
    stray = 1'b0;
    while (!ifa.frame_start && cnt < 100) begin
      tick();
      cnt++;
      if (!ifa.frame_start && ifa.HV_triggers != 48'd0) stray = 1'b1;
    end
    check("restart_latency", 81'(cnt), 81'(4));
    check("no_stray_trig", 81'(stray), 81'(0));

    // Random reset bursts; the model keeps checking every clk.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(20, 2500)) tick();
      reset = 1'b1;
      repeat ($urandom_range(1, 5)) tick();
      reset = 1'b0;
    end
    repeat (600) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vid_sync_hv_gen.md
Name: vid_sync_hv_gen

Overview:
- Raster timing source that sits directly upstream of the OSD/layer generator.
- Produces the sub-pixel clock phase `pc_ena`, and the `hde_in`, `vde_in`, `hs_in` and `vs_in` signals.
- Produces the 48-bit `HV_triggers` bus consumed by the layer engines (line-reset and window-position triggers) and by the test-cursor overlay.
- Also exports the raster position and a frame-start pulse for host and status logic.

Parameters:
- PC_DIV, 4, clk cycles per pixel (1..16); `pc_ena` counts 0..PC_DIV-1.
- H_ACTIVE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, active lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- HS_POL, 0, hs active level (0 = active-low).
- VS_POL, 0, vs active level (0 = active-low).
- Derived: H_TOTAL = sum of the four H values (800); V_TOTAL = sum of the four V values (525).
- Legality constraint: H_SYNC + H_BACK >= 48.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pc_ena  out  4  sub-pixel phase; a pixel boundary occurs where the value becomes 0.
- hde  out  1  horizontal display enable.
- vde  out  1  vertical display enable.
- hs  out  1  horizontal sync, polarity per HS_POL.
- vs  out  1  vertical sync, polarity per VS_POL.
- HV_triggers  out  48  per-pixel trigger strobes.
- frame_start  out  1  high for one pixel at position (0,0).
- raster_x  out  12  current h position.
- raster_y  out  12  current v position.

Behaviour:
- Counters:
  - `pc_ena` increments every clk and wraps from PC_DIV-1 to 0.
  - With PC_DIV=1, `pc_ena` is constantly 0.
  - "Advance" = clk edge on which `pc_ena` == PC_DIV-1.
  - On advance, h increments; h wraps from H_TOTAL-1 to 0.
  - On an h wrap, v increments; v wraps from V_TOTAL-1 to 0.
- Horizontal layout:
  - h 0..H_ACTIVE-1 is active.
  - Front porch follows, then sync at h 656..751, then back porch at h 752..799.
- Vertical layout:
  - v 0..V_ACTIVE-1 is active.
  - Sync lines are v 490..491.
- Output timing:
  - All outputs are registered and loaded on the advance edge from a decode of the NEW position.
  - Outputs therefore change only on edges where `pc_ena` becomes 0, and hold for PC_DIV clks.
  - `raster_x` / `raster_y` equal the new position.
- Decode rules:
  - hde = (h < H_ACTIVE).
  - vde = (v < V_ACTIVE).
  - hs = HS_POL when h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), else ~HS_POL.
  - vs follows the same rule on v with the V parameters and VS_POL.
  - frame_start = (h==0 && v==0).
- Triggers:
  - HV_triggers[k] (k = 0..47) is 1 iff h == H_TOTAL-48+k AND the next line is active, i.e. v == V_TOTAL-1 or v < V_ACTIVE-1.
  - At most one trigger bit is high at a time.
  - No trigger fires on the last active line or on blanking lines other than V_TOTAL-1.
- Reset:
  - While reset is high: pc_ena = 0, internal position = (H_TOTAL-1, V_TOTAL-1).
  - Outputs during reset: hde = vde = frame_start = 0, HV_triggers = 0, raster_x = raster_y = 0, hs = ~HS_POL, vs = ~VS_POL.
  - Reset overrides an advance on the same edge.
  - Reset asserted mid-frame restarts cleanly with no partial pulses afterwards.
- First pixel after reset:
  - After reset deasserts, `pc_ena` steps 0,1,..,PC_DIV-1.
  - The next edge advances to (0,0): hde = vde = frame_start = 1.
- Width rule: all counters are sized for 12 bits; H_TOTAL and V_TOTAL must be <= 4096.

Test Plan:
- Default params; release reset at edge E0 -> pc_ena reads 1,2,3 on E1..E3. At E4 pc_ena=0, hde=vde=frame_start=1, raster=(0,0). frame_start drops at E8.
- Run one full line -> hde high for 640×4 = 2560 clks; hs low from h=656 through h=751 (384 clks); raster_x wraps 799->0 with raster_y 0->1.
- Run a full frame -> vs low only on v=490,491; vde low on v 480..524; frame_start period exactly 800×525×4 = 1,680,000 clks.
- Triggers -> HV_triggers[k] is a one-hot pulse at h=752+k on v=524 and on v=0..478. Bit 8 fires at h=760, bit 18 at h=770. All bits are 0 on v=479..523.
- Assert reset for 3 clks at h=300, v=200 -> outputs hold reset values during reset. After release, the sequence restarts at (0,0) exactly PC_DIV clks later with no stray trigger pulses.
- PC_DIV=1, HS_POL=VS_POL=1 -> pc_ena constantly 0; position advances every clk; hs high for 96 consecutive clks per line.
